decoder_ctrl: RTL and testbench

Shares the single combinational 2-to-3 select decoder between REQ_NUM requesters. Round-robin arbitration picks one requester, drives its 2-bit select onto the decoder, captures the decoded {a,b,c} and returns it tagged with the requester id. It also checks each result against the golden decode table and flags mismatches. The block sits between the requester agents and the decoder instance in the coverage lab top.

---
 rtl/decoder_ctrl_pkg.sv | 26 ++
 rtl/decoder_ctrl_rr_arbiter.sv | 39 +++
 rtl/decoder_ctrl.sv | 175 +++++++++++++++++
 tb/tb_decoder_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_ctrl_pkg.sv
// Shared definitions for decoder_ctrl: FSM states, the safe select code
// and the golden 2-to-3 decode table, which the testbench also imports.
package decoder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Select code parked on the decoder whenever no transaction is active.
  // It decodes to 3'b000.
  localparam logic [1:0] SAFE_SEL = 2'b01;

  // Reference decode: any odd code -> 000, 00 -> 011, 10 -> 111.
  function automatic logic [2:0] golden_abc(input logic [1:0] s);
    logic [2:0] r;
    case (s)
      2'b00:   r = 3'b011;
      2'b10:   r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decoder_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one position past
// last_grant and wraps, so the most recently served requester has the
// lowest priority. Produces a one-hot grant plus its encoded index.
module rr_arbiter
  import decoder_ctrl_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int ID_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [REQ_NUM-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);

  logic found_s;

  // Pick the first requester after last_grant, wrapping modulo REQ_NUM.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found_s  = 1'b0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (!found_s && req[i] && (i == ((int'(last_grant) + k) % REQ_NUM))) begin
          found_s  = 1'b1;
          grant[i] = 1'b1;
          grant_id = ID_W'(i);
        end else begin
          found_s  = found_s;
        end
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/decoder_ctrl.sv
// decoder_ctrl: shares one 2-to-3 select decoder between REQ_NUM requesters.
// Round-robin grant in IDLE, one settle cycle in DRIVE, then the captured
// {a,b,c} is presented tagged with the requester id and a golden-table
// mismatch flag until it is consumed.
// Optional build macro DECODER_CTRL_STATS_EN adds saturating per-code
// response counters (stat_cnt) and an error counter (stat_err).
module decoder_ctrl
  import decoder_ctrl_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int ID_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
`ifdef DECODER_CTRL_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [REQ_NUM-1:0]   req_valid,
  input  logic [2*REQ_NUM-1:0] req_sel,
  output logic [REQ_NUM-1:0]   req_ready,
  output logic [1:0]           dec_s,
  input  logic                 dec_a,
  input  logic                 dec_b,
  input  logic                 dec_c,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [2:0]           resp_abc,
  output logic                 resp_err
`ifdef DECODER_CTRL_STATS_EN
  , output logic [4*CNT_W-1:0] stat_cnt,
  output logic [CNT_W-1:0]     stat_err
`endif
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ID_W-1:0]     last_grant_r;
  logic [ID_W-1:0]     grant_id_r;
  logic [REQ_NUM-1:0]  grant_s;
  logic [ID_W-1:0]     grant_idx_s;
  logic                any_req_s;
  logic [1:0]          sel_mux_s;
  logic [2:0]          abc_s;
  logic                hs_resp_s;

  assign abc_s     = {dec_a, dec_b, dec_c};
  assign hs_resp_s = (state_r == RESP) && resp_valid && resp_ready;

  rr_arbiter #(
    .REQ_NUM (REQ_NUM),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .grant_id   (grant_idx_s),
    .any_req    (any_req_s)
  );

  // Route only the granted requester's select code; masked slices contribute
  // zero so X on non-granted inputs cannot leak into dec_s.
  always_comb begin
    sel_mux_s = 2'b00;
    for (int i = 0; i < REQ_NUM; i++) begin
      sel_mux_s = sel_mux_s | (grant_s[i] ? req_sel[2*i +: 2] : 2'b00);
    end
  end

  // Accept pulse is only offered in IDLE and never while reset is applied.
  always_comb begin
    if (aresetn && (state_r == IDLE)) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic: IDLE -> DRIVE on any request, DRIVE -> RESP always,
  // RESP -> IDLE on the response handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = DRIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE: state_nxt_s = RESP;
      RESP: begin
        if (hs_resp_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and all registered outputs / transaction context.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= IDLE;
      dec_s        <= SAFE_SEL;
      last_grant_r <= ID_W'(REQ_NUM - 1);
      grant_id_r   <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_abc     <= 3'b000;
      resp_err     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            dec_s      <= sel_mux_s;
            grant_id_r <= grant_idx_s;
          end else begin
            dec_s      <= SAFE_SEL;
          end
        end
        DRIVE: begin
          resp_abc   <= abc_s;
          resp_id    <= grant_id_r;
          resp_err   <= (abc_s != golden_abc(dec_s));
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (hs_resp_s) begin
            resp_valid   <= 1'b0;
            last_grant_r <= grant_id_r;
            dec_s        <= SAFE_SEL;
          end else begin
            resp_valid   <= resp_valid;
          end
        end
        default: begin
          dec_s <= SAFE_SEL;
        end
      endcase
    end
  end

`ifdef DECODER_CTRL_STATS_EN
  // Increment by one unless already at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Completed-response statistics, updated on the response handshake.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stat_cnt <= '0;
      stat_err <= '0;
    end else if (hs_resp_s) begin
      for (int k = 0; k < 4; k++) begin
        if (dec_s == 2'(k)) begin
          stat_cnt[k*CNT_W +: CNT_W] <= sat_inc(stat_cnt[k*CNT_W +: CNT_W]);
        end
      end
      if (resp_err) begin
        stat_err <= sat_inc(stat_err);
      end
    end
  end
`endif

endmodule

// File: tb/tb_decoder_ctrl.sv
// Self-checking bench for decoder_ctrl: directed requests push expected
// responses into a queue; a monitor pops and compares on every response
// handshake. A behavioural decoder with a fault hook drives dec_a/b/c.
module tb_decoder_ctrl;
  import decoder_ctrl_pkg::*;

  localparam int REQ_NUM = 4;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] abc;
    logic       err;
  } exp_t;

  logic               clk = 1'b0;
  logic               aresetn;
  logic [REQ_NUM-1:0] req_valid;
  logic [7:0]         req_sel;
  logic [REQ_NUM-1:0] req_ready;
  logic [1:0]         dec_s;
  logic               dec_a, dec_b, dec_c;
  logic               resp_valid;
  logic               resp_ready;
  logic [ID_W-1:0]    resp_id;
  logic [2:0]         resp_abc;
  logic               resp_err;
`ifdef DECODER_CTRL_STATS_EN
  logic [63:0]        stat_cnt;
  logic [15:0]        stat_err;
`endif

  logic [2:0] model_abc;
  logic       fault_a;
  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;

  logic [1:0] t2_sel [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [2:0] t2_abc [4] = '{3'b011, 3'b000, 3'b111, 3'b000};
  int         t3_ord [5] = '{0, 1, 2, 3, 0};
  logic [2:0] t3_abc [5] = '{3'b011, 3'b000, 3'b111, 3'b000, 3'b011};

  always #5 clk = ~clk;

  decoder_ctrl #(.REQ_NUM(REQ_NUM)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .dec_s      (dec_s),
    .dec_a      (dec_a),
    .dec_b      (dec_b),
    .dec_c      (dec_c),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_abc   (resp_abc),
    .resp_err   (resp_err)
`ifdef DECODER_CTRL_STATS_EN
    , .stat_cnt (stat_cnt),
    .stat_err   (stat_err)
`endif
  );

  // Behavioural 2-to-3 decoder; fault_a forces output a low.
  always_comb begin
    case (dec_s)
      2'b00:   model_abc = 3'b011;
      2'b10:   model_abc = 3'b111;
      default: model_abc = 3'b000;
    endcase
  end
  assign dec_a = model_abc[2] & ~fault_a;
  assign dec_b = model_abc[1];
  assign dec_c = model_abc[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur within bound", name);
  endtask

  // Scoreboard monitor: every response handshake must match the queue head.
  always @(negedge clk) begin
    if (aresetn && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_response");
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_id",  32'(resp_id),  32'(mon_e.id));
        check("resp_abc", 32'(resp_abc), 32'(mon_e.abc));
        check("resp_err", 32'(resp_err), 32'(mon_e.err));
      end
    end
  end

  // Single request from requester r; returns one cycle after acceptance.
  task automatic issue(input int r, input logic [1:0] sel, input logic [2:0] abc, input logic err);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back('{id: 2'(r), abc: abc, err: err});
    req_sel[2*r +: 2] = sel;
    req_valid = 4'b0001 << r;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (|req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("req_ready_timeout");
    else check("req_ready_onehot", 32'(req_ready), 32'(4'b0001 << r));
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  // Wait for the response handshake, then confirm the safe code in IDLE.
  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("resp_timeout");
    @(negedge clk);
    check("idle_dec_s", 32'(dec_s), 32'(2'b01));
  endtask

  initial begin
    int  n;
    int  last;
    bit  got;
    aresetn    = 1'b0;
    req_valid  = 4'b1111;
    req_sel    = 8'h00;
    resp_ready = 1'b1;
    fault_a    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_dec_s",      32'(dec_s),      32'(2'b01));
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_resp_id",    32'(resp_id),    32'd0);
    check("rst_resp_abc",   32'(resp_abc),   32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    req_valid = '0;
    aresetn   = 1'b1;

    // Single request, latency T -> T+1 dec_s -> T+2 resp_valid.
    issue(0, 2'b00, 3'b011, 1'b0);
    @(negedge clk);
    check("t1_dec_s", 32'(dec_s), 32'(2'b00));
    @(negedge clk);
    check("t1_resp_valid", 32'(resp_valid), 32'd1);
    @(negedge clk);
    check("t1_idle_dec_s", 32'(dec_s), 32'(2'b01));

    // All four codes from requester 2.
    for (int i = 0; i < 4; i++) begin
      issue(2, t2_sel[i], t2_abc[i], 1'b0);
      wait_done();
    end

    // Requester 3 served so requester 0 leads the next round.
    issue(3, 2'b11, 3'b000, 1'b0);
    wait_done();

    // All requesters held valid: grants 0,1,2,3,0 three cycles apart.
    @(posedge clk); #1;
    req_sel   = {2'b11, 2'b10, 2'b01, 2'b00};
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) exp_q.push_back('{id: 2'(t3_ord[i]), abc: t3_abc[i], err: 1'b0});
    n = 0;
    last = 0;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      @(negedge clk);
      if (|req_ready) begin
        check("t3_grant", 32'(req_ready), 32'd1 << t3_ord[n]);
        if (n > 0) check("t3_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        n++;
      end
    end
    if (n < 5) fail_now("t3_grant_count");
    @(posedge clk); #1;
    req_valid = '0;
    wait_done();

    // Back-pressure: response held stable, no accepts while waiting.
    resp_ready = 1'b0;
    issue(1, 2'b10, 3'b111, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("t4_resp_valid");
    req_sel[7:6] = 2'b00;
    req_valid[3] = 1'b1;
    exp_q.push_back('{id: 2'd3, abc: 3'b011, err: 1'b0});
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_valid",  32'(resp_valid), 32'd1);
      check("t4_hold_id",     32'(resp_id),    32'd1);
      check("t4_hold_abc",    32'(resp_abc),   32'(3'b111));
      check("t4_hold_dec_s",  32'(dec_s),      32'(2'b10));
      check("t4_no_accept",   32'(req_ready),  32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("t4_release_valid", 32'(resp_valid), 32'd1);
    @(negedge clk);
    check("t4_next_grant", 32'(req_ready), 32'(4'b1000));
    @(posedge clk); #1;
    req_valid = '0;
    wait_done();

    // Fault injection: a stuck low while sel=10.
    fault_a = 1'b1;
    issue(0, 2'b10, 3'b011, 1'b1);
    wait_done();
    fault_a = 1'b0;
`ifdef DECODER_CTRL_STATS_EN
    check("stat_err",  32'(stat_err),        32'd1);
    check("stat_cnt0", 32'(stat_cnt[15:0]),  32'd5);
    check("stat_cnt1", 32'(stat_cnt[31:16]), 32'd2);
    check("stat_cnt2", 32'(stat_cnt[47:32]), 32'd4);
    check("stat_cnt3", 32'(stat_cnt[63:48]), 32'd3);
`endif

    // Reset while a response is pending aborts it.
    resp_ready = 1'b0;
    issue(2, 2'b00, 3'b011, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("t6_resp_valid");
    #2 aresetn = 1'b0;
    #1;
    check("t6_rst_valid",     32'(resp_valid), 32'd0);
    check("t6_rst_dec_s",     32'(dec_s),      32'(2'b01));
    check("t6_rst_resp_id",   32'(resp_id),    32'd0);
    check("t6_rst_resp_abc",  32'(resp_abc),   32'd0);
    check("t6_rst_req_ready", 32'(req_ready),  32'd0);
    exp_q.delete();
    @(negedge clk);
    aresetn    = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_sel   = {2'b11, 2'b10, 2'b01, 2'b00};
    req_valid = 4'b1111;
    exp_q.push_back('{id: 2'd0, abc: 3'b011, err: 1'b0});
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (|req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("t6_grant_timeout");
    else check("t6_first_grant", 32'(req_ready), 32'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    wait_done();

    repeat (3) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
